// File: rtl/tdm_secure_arbiter.sv
// Two-domain time-division arbiter for one shared resource: a fixed low/high slot
// schedule, so the public domain's timing and data never depend on the secret domain.
module tdm_secure_arbiter #(
  parameter int unsigned DW   = 8,
  parameter int unsigned SLOT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lo_req,
  input  logic [DW-1:0] lo_data,
  output logic          lo_gnt,
  output logic          lo_rsp_valid,
  output logic [DW-1:0] lo_rsp_data,
  input  logic          hi_req,
  input  logic [DW-1:0] hi_data,
  output logic          hi_gnt,
  output logic          hi_rsp_valid,
  output logic [DW-1:0] hi_rsp_data,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_owner,
  input  logic [DW-1:0] res_result,
  output logic          res_flush
);

  localparam int unsigned PW = $clog2(SLOT);
  localparam logic [PW-1:0] LAST = PW'(SLOT - 1);

  typedef enum logic {DOM_LO = 1'b0, DOM_HI = 1'b1} dom_e;

  logic [PW-1:0] phase_q, phase_d;
  dom_e          owner_q, owner_d;
  logic          issued_q, issued_d;
  logic          lo_rsp_valid_q, lo_rsp_valid_d;
  logic          hi_rsp_valid_q, hi_rsp_valid_d;
  logic [DW-1:0] lo_rsp_data_q, lo_rsp_data_d;
  logic [DW-1:0] hi_rsp_data_q, hi_rsp_data_d;
  logic          own_req;
  logic [DW-1:0] own_data;
  logic          issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q        <= '0;
      owner_q        <= DOM_LO;
      issued_q       <= 1'b0;
      lo_rsp_valid_q <= 1'b0;
      hi_rsp_valid_q <= 1'b0;
      lo_rsp_data_q  <= '0;
      hi_rsp_data_q  <= '0;
    end else begin
      phase_q        <= phase_d;
      owner_q        <= owner_d;
      issued_q       <= issued_d;
      lo_rsp_valid_q <= lo_rsp_valid_d;
      hi_rsp_valid_q <= hi_rsp_valid_d;
      lo_rsp_data_q  <= lo_rsp_data_d;
      hi_rsp_data_q  <= hi_rsp_data_d;
    end
  end

  always_comb begin
    phase_d        = phase_q + PW'(1);
    owner_d        = owner_q;
    issued_d       = issued_q;
    lo_rsp_valid_d = 1'b0;
    hi_rsp_valid_d = 1'b0;
    lo_rsp_data_d  = lo_rsp_data_q;
    hi_rsp_data_d  = hi_rsp_data_q;
    // Only the slot owner's inputs are ever selected; the other domain is invisible.
    own_req  = (owner_q == DOM_HI) ? hi_req  : lo_req;
    own_data = (owner_q == DOM_HI) ? hi_data : lo_data;
    issue    = !reset && (phase_q == '0) && own_req;

    if (issue) issued_d = 1'b1;

    if (phase_q == PW'(1) && issued_q) begin
      if (owner_q == DOM_HI) begin
        hi_rsp_valid_d = 1'b1;
        hi_rsp_data_d  = res_result;
      end else begin
        lo_rsp_valid_d = 1'b1;
        lo_rsp_data_d  = res_result;
      end
    end

    if (phase_q == LAST) begin
      phase_d  = '0;
      owner_d  = (owner_q == DOM_HI) ? DOM_LO : DOM_HI;
      issued_d = 1'b0;
    end
  end

  assign lo_gnt       = issue && (owner_q == DOM_LO);
  assign hi_gnt       = issue && (owner_q == DOM_HI);
  assign res_valid    = issue;
  assign res_data     = issue ? own_data : '0;
  assign res_owner    = owner_q;
  assign res_flush    = !reset && (phase_q == LAST);
  assign lo_rsp_valid = lo_rsp_valid_q;
  assign hi_rsp_valid = hi_rsp_valid_q;
  assign lo_rsp_data  = lo_rsp_data_q;
  assign hi_rsp_data  = hi_rsp_data_q;

endmodule

// File: tb/tb_tdm_secure_arbiter.sv
// Scoreboard bench for tdm_secure_arbiter: expected responses are queued at grant
// time and retired when their response cycle arrives.
module tb_tdm_secure_arbiter;
  localparam int unsigned DW   = 8;
  localparam int unsigned SLOT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          lo_req, hi_req;
  logic [DW-1:0] lo_data, hi_data;
  logic          lo_gnt, hi_gnt, lo_rsp_valid, hi_rsp_valid;
  logic [DW-1:0] lo_rsp_data, hi_rsp_data;
  logic          res_valid, res_owner, res_flush;
  logic [DW-1:0] res_data, res_result;

  tdm_secure_arbiter #(.DW(DW), .SLOT(SLOT)) dut (
    .clock        (clock),
    .reset        (reset),
    .lo_req       (lo_req),
    .lo_data      (lo_data),
    .lo_gnt       (lo_gnt),
    .lo_rsp_valid (lo_rsp_valid),
    .lo_rsp_data  (lo_rsp_data),
    .hi_req       (hi_req),
    .hi_data      (hi_data),
    .hi_gnt       (hi_gnt),
    .hi_rsp_valid (hi_rsp_valid),
    .hi_rsp_data  (hi_rsp_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_owner    (res_owner),
    .res_result   (res_result),
    .res_flush    (res_flush)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          dom;
    logic [DW-1:0] val;
    int            due;
  } rsp_t;

  rsp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          pend = 1'b0;
  logic [DW-1:0] pend_val = '0;
  logic [DW-1:0] exp_lo_data = '0;
  logic [DW-1:0] exp_hi_data = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: drive at its start, check just before its closing edge.
  task automatic cycle_step(input logic lr, input logic [DW-1:0] ld,
                            input logic hr, input logic [DW-1:0] hd);
    int            ph;
    logic          own, lg, hg, lv, hv;
    logic [DW-1:0] ed;
    rsp_t          it;
    lo_req     = lr;
    lo_data    = ld;
    hi_req     = hr;
    hi_data    = hd;
    res_result = pend ? pend_val : DW'($urandom);
    pend       = 1'b0;
    ph  = cyc % SLOT;
    own = ((cyc / SLOT) % 2) == 1;
    @(negedge clock);
    lg = (ph == 0) && !own && lr;
    hg = (ph == 0) && own && hr;
    ed = lg ? ld : (hg ? hd : '0);
    check("lo_gnt", lo_gnt, lg);
    check("hi_gnt", hi_gnt, hg);
    check("res_valid", res_valid, lg | hg);
    check("res_data", res_data, ed);
    check("res_flush", res_flush, ph == SLOT - 1);
    check("res_owner", res_owner, own);
    if (lg || hg) begin
      it.dom = own;
      it.val = DW'($urandom);
      it.due = cyc + 2;
      sb.push_back(it);
      pend     = 1'b1;
      pend_val = it.val;
    end
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check("rsp_overdue", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    lv = 1'b0;
    hv = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      it = sb.pop_front();
      if (it.dom) begin
        hv = 1'b1;
        exp_hi_data = it.val;
      end else begin
        lv = 1'b1;
        exp_lo_data = it.val;
      end
    end
    check("lo_rsp_valid", lo_rsp_valid, lv);
    check("hi_rsp_valid", hi_rsp_valid, hv);
    check("lo_rsp_data", lo_rsp_data, exp_lo_data);
    check("hi_rsp_data", hi_rsp_data, exp_hi_data);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Asserted mid-cycle so the clear is observed before any clock edge.
  task automatic apply_reset(input logic lr);
    reset   = 1'b1;
    lo_req  = lr;
    hi_req  = 1'b1;
    lo_data = DW'($urandom);
    hi_data = DW'($urandom);
    #2;
    check("rst_lo_gnt", lo_gnt, 1'b0);
    check("rst_hi_gnt", hi_gnt, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    check("rst_res_flush", res_flush, 1'b0);
    check("rst_res_owner", res_owner, 1'b0);
    check("rst_lo_rsp_valid", lo_rsp_valid, 1'b0);
    check("rst_hi_rsp_valid", hi_rsp_valid, 1'b0);
    check("rst_lo_rsp_data", lo_rsp_data, '0);
    check("rst_hi_rsp_data", hi_rsp_data, '0);
    sb.delete();
    pend        = 1'b0;
    exp_lo_data = '0;
    exp_hi_data = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    reset      = 1'b1;
    lo_req     = 1'b0;
    hi_req     = 1'b0;
    lo_data    = '0;
    hi_data    = '0;
    res_result = '0;
    @(posedge clock);
    #1;

    apply_reset(1'b0);
    for (int c = 0; c < 16; c++) cycle_step(1'b0, '0, 1'b0, '0);

    apply_reset(1'b0);
    for (int c = 0; c < 16; c++) cycle_step(c == 0, 8'h05, c <= 4, 8'hA7);

    // Grant in cycle 0, then reset during cycle 1 kills the pending response.
    apply_reset(1'b0);
    cycle_step(1'b1, 8'h55, 1'b0, '0);
    apply_reset(1'b1);
    for (int c = 0; c < 10; c++) cycle_step(1'b1, 8'h33, 1'b0, '0);

    apply_reset(1'b0);
    for (int c = 0; c < 12; c++) cycle_step(c != 0, 8'h21, 1'b0, '0);

    apply_reset(1'b0);
    for (int c = 0; c < 5; c++) cycle_step(1'b0, '0, 1'b1, DW'($urandom));

    apply_reset(1'b0);
    for (int c = 0; c < 200; c++)
      cycle_step(1'($urandom_range(0, 1)), DW'($urandom),
                 1'($urandom_range(0, 1)), DW'($urandom));
    for (int c = 0; c < 4; c++) cycle_step(1'b0, '0, 1'b0, '0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
